// File: rtl/vmicro16_timer_apb_pkg.sv
// Shared constants for the vmicro16 timer peripheral: register offsets, CTRL bit
// positions, interconnect slot/address window and the APB handshake state type.
package vmicro16_timer_apb_pkg;

    localparam int TIMER_REG_CTRL   = 0;
    localparam int TIMER_REG_LOAD   = 1;
    localparam int TIMER_REG_COUNT  = 2;
    localparam int TIMER_REG_STATUS = 3;
    localparam int TIMER_REG_PRESC  = 4;

    localparam int TIMER_CTRL_EN          = 0;
    localparam int TIMER_CTRL_AUTO_RELOAD = 1;
    localparam int TIMER_CTRL_IRQ_EN      = 2;
    localparam int TIMER_CTRL_BITS        = 3;

    localparam int          APB_PSELX_TIMER0 = 3;
    localparam logic [15:0] DEF_MMU_TIMER0_S = 16'h0140;
    localparam logic [15:0] DEF_MMU_TIMER0_E = 16'h0147;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_WAIT,
        APB_RESP
    } apb_state_t;

endpackage

// File: rtl/vmicro16_apb_slave_fsm.sv
// Generic APB responder handshake: latches the setup phase, inserts WAIT_STATES
// PREADY=0 cycles and produces one-cycle PREADY plus matching read/write strobes.
module vmicro16_apb_slave_fsm
    import vmicro16_timer_apb_pkg::*;
#(
    parameter int BUS_WIDTH   = 16,
    parameter int ADDR_BITS   = 3,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] paddr,
    input  logic                 pwrite,
    input  logic                 psel,
    input  logic                 penable,
    input  logic [BUS_WIDTH-1:0] pwdata,
    output logic [ADDR_BITS-1:0] addr,
    output logic [BUS_WIDTH-1:0] wdata,
    output logic                 wr_strobe,
    output logic                 rd_strobe,
    output logic                 pready
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    apb_state_t           state_reg;
    logic [3:0]           wait_cnt_reg;
    logic                 write_reg;
    logic [ADDR_BITS-1:0] addr_reg;
    logic [BUS_WIDTH-1:0] wdata_reg;
    logic                 pready_reg;
    logic                 wr_strobe_reg;
    logic                 rd_strobe_reg;

    // Only the low offset bits are decoded; the interconnect already selected us.
    logic unused_paddr;
    assign unused_paddr = ^paddr[BUS_WIDTH-1:ADDR_BITS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= APB_IDLE;
            wait_cnt_reg  <= '0;
            write_reg     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            pready_reg    <= 1'b0;
            wr_strobe_reg <= 1'b0;
            rd_strobe_reg <= 1'b0;
        end else begin
            pready_reg    <= 1'b0;
            wr_strobe_reg <= 1'b0;
            rd_strobe_reg <= 1'b0;
            case (state_reg)
                APB_IDLE: begin
                    if (psel && !penable) begin
                        addr_reg     <= paddr[ADDR_BITS-1:0];
                        write_reg    <= pwrite;
                        wdata_reg    <= pwdata;
                        wait_cnt_reg <= WAIT_INIT;
                        state_reg    <= APB_WAIT;
                    end
                end
                APB_WAIT: begin
                    if (!psel) begin
                        state_reg <= APB_IDLE;
                    end else if (penable) begin
                        if (wait_cnt_reg == 4'd0) begin
                            state_reg     <= APB_RESP;
                            pready_reg    <= 1'b1;
                            wr_strobe_reg <= write_reg;
                            rd_strobe_reg <= !write_reg;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg - 4'd1;
                        end
                    end
                end
                APB_RESP: state_reg <= APB_IDLE;
                default:  state_reg <= APB_IDLE;
            endcase
        end
    end

    assign addr      = addr_reg;
    assign wdata     = wdata_reg;
    assign wr_strobe = wr_strobe_reg;
    assign rd_strobe = rd_strobe_reg;
    assign pready    = pready_reg;

endmodule

// File: rtl/vmicro16_timer_apb.sv
// APB 16-bit down-counting timer with auto-reload, sticky expiry flag and irq.
// Build option: define VMICRO16_TIMER_PRESCALER_EN to add the PRESC register at offset 4.
module vmicro16_timer_apb
    import vmicro16_timer_apb_pkg::*;
#(
    parameter int BUS_WIDTH   = 16,
    parameter int ADDR_BITS   = 3,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] S_PADDR,
    input  logic                 S_PWRITE,
    input  logic                 S_PSELx,
    input  logic                 S_PENABLE,
    input  logic [BUS_WIDTH-1:0] S_PWDATA,
    output logic [BUS_WIDTH-1:0] S_PRDATA,
    output logic                 S_PREADY,
    output logic                 irq
);

    logic [ADDR_BITS-1:0] reg_addr;
    logic [BUS_WIDTH-1:0] reg_wdata;
    logic                 wr_strobe;
    logic                 rd_strobe;

    vmicro16_apb_slave_fsm #(
        .BUS_WIDTH  (BUS_WIDTH),
        .ADDR_BITS  (ADDR_BITS),
        .WAIT_STATES(WAIT_STATES)
    ) u_apb_fsm (
        .clk      (clk),
        .reset    (reset),
        .paddr    (S_PADDR),
        .pwrite   (S_PWRITE),
        .psel     (S_PSELx),
        .penable  (S_PENABLE),
        .pwdata   (S_PWDATA),
        .addr     (reg_addr),
        .wdata    (reg_wdata),
        .wr_strobe(wr_strobe),
        .rd_strobe(rd_strobe),
        .pready   (S_PREADY)
    );

    logic [TIMER_CTRL_BITS-1:0] ctrl_reg;
    logic [BUS_WIDTH-1:0]       load_reg;
    logic [BUS_WIDTH-1:0]       count_reg;
    logic                       expired_reg;
    logic                       tick;
    logic                       wr_ctrl, wr_load, wr_count, wr_status;
    logic [BUS_WIDTH-1:0]       rdata;

    assign wr_ctrl   = wr_strobe && (reg_addr == ADDR_BITS'(TIMER_REG_CTRL));
    assign wr_load   = wr_strobe && (reg_addr == ADDR_BITS'(TIMER_REG_LOAD));
    assign wr_count  = wr_strobe && (reg_addr == ADDR_BITS'(TIMER_REG_COUNT));
    assign wr_status = wr_strobe && (reg_addr == ADDR_BITS'(TIMER_REG_STATUS));

`ifdef VMICRO16_TIMER_PRESCALER_EN
    logic [BUS_WIDTH-1:0] presc_reg;
    logic [BUS_WIDTH-1:0] pcnt_reg;
    logic                 wr_presc;

    assign wr_presc = wr_strobe && (reg_addr == ADDR_BITS'(TIMER_REG_PRESC));
    assign tick     = (pcnt_reg == presc_reg);

    // Prescale counter only runs while the timer is enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg <= '0;
            pcnt_reg  <= '0;
        end else begin
            if (wr_presc) begin
                presc_reg <= reg_wdata;
            end
            if (wr_presc || wr_ctrl) begin
                pcnt_reg <= '0;
            end else if (ctrl_reg[TIMER_CTRL_EN]) begin
                pcnt_reg <= tick ? '0 : pcnt_reg + BUS_WIDTH'(1);
            end
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Statement order sets priority: a status clear loses to a new expiry,
    // while CTRL/LOAD/COUNT writes override whatever the timer did this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_reg    <= '0;
            load_reg    <= '0;
            count_reg   <= '0;
            expired_reg <= 1'b0;
        end else begin
            if (wr_status && reg_wdata[0]) begin
                expired_reg <= 1'b0;
            end
            if (ctrl_reg[TIMER_CTRL_EN] && tick) begin
                if (count_reg != '0) begin
                    count_reg <= count_reg - BUS_WIDTH'(1);
                end else begin
                    expired_reg <= 1'b1;
                    if (ctrl_reg[TIMER_CTRL_AUTO_RELOAD]) begin
                        count_reg <= load_reg;
                    end else begin
                        ctrl_reg[TIMER_CTRL_EN] <= 1'b0;
                    end
                end
            end
            if (wr_ctrl) begin
                ctrl_reg <= reg_wdata[TIMER_CTRL_BITS-1:0];
            end
            if (wr_load) begin
                load_reg <= reg_wdata;
            end
            if (wr_count) begin
                count_reg <= reg_wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_strobe) begin
            case (reg_addr)
                ADDR_BITS'(TIMER_REG_CTRL):   rdata = BUS_WIDTH'(ctrl_reg);
                ADDR_BITS'(TIMER_REG_LOAD):   rdata = load_reg;
                ADDR_BITS'(TIMER_REG_COUNT):  rdata = count_reg;
                ADDR_BITS'(TIMER_REG_STATUS): rdata = BUS_WIDTH'(expired_reg);
`ifdef VMICRO16_TIMER_PRESCALER_EN
                ADDR_BITS'(TIMER_REG_PRESC):  rdata = presc_reg;
`endif
                default:                      rdata = '0;
            endcase
        end
    end

    assign S_PRDATA = rdata;
    assign irq      = expired_reg & ctrl_reg[TIMER_CTRL_IRQ_EN];

endmodule

// File: tb/tb_vmicro16_timer_apb.sv
// Bench for vmicro16_timer_apb: one instance with 0 and one with 3 wait states,
// a register-level model checked every cycle, plus directed literal expectations.
module tb_vmicro16_timer_apb;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [15:0] load;
        logic [15:0] count;
        logic [15:0] presc;
        logic [15:0] pcnt;
        logic        exp;
    } m_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] paddr = '0;
    logic [15:0] pwdata = '0;
    logic        pwrite = 1'b0;
    logic        penable = 1'b0;
    logic [1:0]  psel = '0;
    logic [15:0] prdata [2];
    logic        pready [2];
    logic        irq [2];

    m_t          m [2];
    logic        mw_en [2];
    logic [2:0]  mw_addr = '0;
    logic [15:0] mw_data = '0;
    logic        exp_ready [2];
    logic        exp_write = 1'b0;
    logic [2:0]  exp_addr = '0;
    logic        checking = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    vmicro16_timer_apb #(.BUS_WIDTH(16), .ADDR_BITS(3), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel[0]),
        .S_PENABLE(penable), .S_PWDATA(pwdata), .S_PRDATA(prdata[0]),
        .S_PREADY(pready[0]), .irq(irq[0])
    );

    vmicro16_timer_apb #(.BUS_WIDTH(16), .ADDR_BITS(3), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset), .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel[1]),
        .S_PENABLE(penable), .S_PWDATA(pwdata), .S_PRDATA(prdata[1]),
        .S_PREADY(pready[1]), .irq(irq[1])
    );

    function automatic int ws(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    // Next register state after one clock, from the timer rules and an optional committed write.
    function automatic m_t model_next(input m_t s, input logic wen, input logic [2:0] wa,
                                      input logic [15:0] wd);
        m_t   n;
        logic tick;
        logic fired;
        n = s;
        tick = 1'b1;
`ifdef VMICRO16_TIMER_PRESCALER_EN
        tick = (s.pcnt == s.presc);
        if (s.ctrl[0]) n.pcnt = tick ? 16'd0 : s.pcnt + 16'd1;
`endif
        fired = s.ctrl[0] && tick && (s.count == 16'd0);
        if (s.ctrl[0] && tick) begin
            if (fired) begin
                n.exp = 1'b1;
                if (s.ctrl[1]) n.count = s.load;
                else n.ctrl[0] = 1'b0;
            end else begin
                n.count = s.count - 16'd1;
            end
        end
        if (wen) begin
            case (wa)
                3'd0: begin n.ctrl = wd[2:0]; n.pcnt = 16'd0; end
                3'd1: n.load = wd;
                3'd2: n.count = wd;
                3'd3: if (wd[0] && !fired) n.exp = 1'b0;
`ifdef VMICRO16_TIMER_PRESCALER_EN
                3'd4: begin n.presc = wd; n.pcnt = 16'd0; end
`endif
                default: ;
            endcase
        end
        return n;
    endfunction

    function automatic logic [15:0] model_read(input m_t s, input logic [2:0] a);
        case (a)
            3'd0: return {13'd0, s.ctrl};
            3'd1: return s.load;
            3'd2: return s.count;
            3'd3: return {15'd0, s.exp};
`ifdef VMICRO16_TIMER_PRESCALER_EN
            3'd4: return s.presc;
`endif
            default: return 16'd0;
        endcase
    endfunction

    task automatic chk(input string name, input int i, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %04h expected %04h", name, i, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m[i] <= reset ? '0 : model_next(m[i], mw_en[i], mw_addr, mw_data);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                chk("irq", i, {15'd0, irq[i]}, {15'd0, m[i].exp & m[i].ctrl[2]});
                chk("pready", i, {15'd0, pready[i]}, {15'd0, exp_ready[i]});
                chk("prdata", i, prdata[i],
                    (exp_ready[i] && !exp_write) ? model_read(m[i], exp_addr) : 16'd0);
            end
        end
    end

    // stop_at: index of the access-phase cycle at which the transfer is cut short
    // (-1 = never), either by dropping PSEL or by pulsing reset.
    task automatic apb(input int i, input logic wr, input logic [2:0] a, input logic [15:0] d,
                       input int stop_at, input logic stop_by_reset, output logic [15:0] rd);
        logic done;
        done = 1'b0;
        rd = '0;
        @(posedge clk); #1;
        psel[i] = 1'b1; penable = 1'b0; pwrite = wr; paddr = {13'h0A5, a}; pwdata = d;
        for (int k = 0; k <= ws(i) + 1 && !done; k++) begin
            @(posedge clk); #1;
            if (k == stop_at) begin
                done = 1'b1;
                if (stop_by_reset) begin
                    reset = 1'b1; penable = 1'b1;
                end else begin
                    psel[i] = 1'b0; penable = 1'b0;
                end
            end else begin
                penable = 1'b1;
                if (k == ws(i) + 1) begin
                    exp_ready[i] = 1'b1; exp_write = wr; exp_addr = a;
                    mw_en[i] = wr; mw_addr = a; mw_data = d;
                    @(negedge clk);
                    rd = prdata[i];
                end
            end
        end
        @(posedge clk); #1;
        reset = 1'b0; psel[i] = 1'b0; penable = 1'b0; exp_ready[i] = 1'b0; mw_en[i] = 1'b0;
        $display("apb%0d %s off=%0d wdata=%04h rdata=%04h stop_at=%0d", i, wr ? "WR" : "RD",
                 a, d, rd, stop_at);
    endtask

    task automatic wr(input int i, input logic [2:0] a, input logic [15:0] d);
        logic [15:0] t;
        apb(i, 1'b1, a, d, -1, 1'b0, t);
    endtask

    task automatic rdc(input int i, input logic [2:0] a, input logic [15:0] e, input string name);
        logic [15:0] t;
        apb(i, 1'b0, a, 16'h0000, -1, 1'b0, t);
        chk(name, i, t, e);
    endtask

    initial begin
        logic [15:0] t;
        for (int i = 0; i < 2; i++) begin
            mw_en[i] = 1'b0;
            exp_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 checking = 1'b1;
        @(negedge clk);
        chk("rst_pready", 0, {15'd0, pready[0]}, 16'd0);
        chk("rst_prdata", 1, prdata[1], 16'd0);
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 4; a++) rdc(i, 3'(a), 16'h0000, "rst_reg");
        end

        // Auto-reload: LOAD=5, CTRL=en|auto_reload
        wr(0, 3'd1, 16'd5);
        wr(0, 3'd0, 16'd3);
        rdc(0, 3'd2, 16'd3, "ar_count_a");
        rdc(0, 3'd2, 16'd5, "ar_count_reload");
        rdc(0, 3'd2, 16'd1, "ar_count_b");
        rdc(0, 3'd3, 16'd1, "ar_status");

        // One-shot, write-0/write-1 semantics of STATUS
        wr(0, 3'd0, 16'd0);
        wr(0, 3'd2, 16'd2);
        wr(0, 3'd3, 16'd0);
        rdc(0, 3'd3, 16'd1, "status_w0");
        wr(0, 3'd3, 16'd1);
        rdc(0, 3'd3, 16'd0, "status_w1");
        wr(0, 3'd0, 16'd1);
        rdc(0, 3'd2, 16'd0, "os_count");
        rdc(0, 3'd0, 16'd0, "os_ctrl_en");
        rdc(0, 3'd3, 16'd1, "os_status");

        // irq and clear
        wr(0, 3'd3, 16'd1);
        wr(0, 3'd2, 16'd1);
        wr(0, 3'd0, 16'd5);
        repeat (3) @(negedge clk);
        chk("irq_set", 0, {15'd0, irq[0]}, 16'd1);
        wr(0, 3'd3, 16'd1);
        @(negedge clk);
        chk("irq_clr", 0, {15'd0, irq[0]}, 16'd0);

        // LOAD=0 auto-reload expires every tick, so a clear never sticks
        wr(0, 3'd1, 16'd0);
        wr(0, 3'd2, 16'd0);
        wr(0, 3'd0, 16'd7);
        wr(0, 3'd3, 16'd1);
        rdc(0, 3'd3, 16'd1, "clr_vs_set");
        @(negedge clk);
        chk("irq_stuck", 0, {15'd0, irq[0]}, 16'd1);
        wr(0, 3'd2, 16'h0100);
        rdc(0, 3'd2, 16'h00FD, "count_wr_wins");
        wr(0, 3'd0, 16'd0);

        // Unmapped offsets
        wr(0, 3'd6, 16'hFFFF);
        rdc(0, 3'd6, 16'h0000, "off6");
        wr(0, 3'd5, 16'h1234);
        rdc(0, 3'd5, 16'h0000, "off5");
`ifdef VMICRO16_TIMER_PRESCALER_EN
        wr(0, 3'd4, 16'd3);
        rdc(0, 3'd4, 16'd3, "presc_rd");
        wr(0, 3'd2, 16'd2);
        wr(0, 3'd3, 16'd1);
        wr(0, 3'd0, 16'd1);
        rdc(0, 3'd2, 16'd2, "presc_cnt_a");
        rdc(0, 3'd2, 16'd1, "presc_cnt_b");
        rdc(0, 3'd3, 16'd0, "presc_st_a");
        rdc(0, 3'd3, 16'd1, "presc_st_b");
`else
        wr(0, 3'd4, 16'h1234);
        rdc(0, 3'd4, 16'h0000, "off4");
`endif

        // Wait states, aborts and reset mid-transfer
        wr(1, 3'd1, 16'hBEEF);
        rdc(1, 3'd1, 16'hBEEF, "ws3_load");
        rdc(1, 3'd6, 16'h0000, "ws3_off6");
        apb(1, 1'b1, 3'd1, 16'h1111, 2, 1'b0, t);
        rdc(1, 3'd1, 16'hBEEF, "abort_ws3");
        wr(0, 3'd1, 16'h5A5A);
        apb(0, 1'b1, 3'd1, 16'h2222, 0, 1'b0, t);
        rdc(0, 3'd1, 16'h5A5A, "abort_ws0");
        wr(1, 3'd2, 16'h0042);
        apb(1, 1'b1, 3'd1, 16'h3333, 1, 1'b1, t);
        rdc(1, 3'd1, 16'h0000, "rst_mid_load");
        rdc(1, 3'd2, 16'h0000, "rst_mid_count");
        rdc(0, 3'd1, 16'h0000, "rst_mid_ws0");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
